// File: rtl/gb_cpu_bus_ctrl.sv
// CPU-side memory bus controller: sequences one byte access over T1..T4 (plus optional wait
// states) and returns read data to the register file through a single write port.

package gb_cpu_bus_pkg;

  // 8-bit register file slots; REG_IR/REG_TMP_H/REG_TMP_L are the only legal read targets.
  typedef enum logic [3:0] {
    REG_A, REG_F, REG_B, REG_C, REG_D, REG_E, REG_H, REG_L,
    REG_SP_H, REG_SP_L, REG_PC_H, REG_PC_L, REG_IR, REG_TMP_H, REG_TMP_L, REG_UNUSED
  } regfile_r8_t;

  // 16-bit register pairs usable as an address source.
  typedef enum logic [2:0] {
    REG_AF, REG_BC, REG_DE, REG_HL, REG_SP, REG_PC, REG_TMP
  } regfile_r16_t;

  // Whole register file, one byte per regfile_r8_t slot.
  typedef logic [15:0][7:0] regfile_t;

  function automatic regfile_r8_t pair_high(regfile_r16_t sel);
    case (sel)
      REG_AF:  return REG_A;
      REG_BC:  return REG_B;
      REG_DE:  return REG_D;
      REG_HL:  return REG_H;
      REG_SP:  return REG_SP_H;
      REG_PC:  return REG_PC_H;
      default: return REG_TMP_H;
    endcase
  endfunction

  function automatic regfile_r8_t pair_low(regfile_r16_t sel);
    case (sel)
      REG_AF:  return REG_F;
      REG_BC:  return REG_C;
      REG_DE:  return REG_E;
      REG_HL:  return REG_L;
      REG_SP:  return REG_SP_L;
      REG_PC:  return REG_PC_L;
      default: return REG_TMP_L;
    endcase
  endfunction

  function automatic logic [7:0] getRegisterHigh(regfile_t regs, regfile_r16_t sel);
    return regs[pair_high(sel)];
  endfunction

  function automatic logic [7:0] getRegisterLow(regfile_t regs, regfile_r16_t sel);
    return regs[pair_low(sel)];
  endfunction

endpackage

module gb_cpu_bus_ctrl
  import gb_cpu_bus_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  regfile_t     registers,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  regfile_r16_t req_addr_sel,
  input  logic         req_high_page,
  input  regfile_r8_t  req_wdata_sel,
  input  regfile_r8_t  req_dest,
  output logic [15:0]  mem_addr,
  output logic [7:0]   mem_wdata,
  output logic         mem_rd,
  output logic         mem_wr,
  input  logic [7:0]   mem_rdata,
  output regfile_r8_t  data_bus_req,
  output logic [7:0]   data_bus_data,
  output logic         data_bus_wren,
  output logic         bad_dest
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_T1   = 3'd1;
  localparam logic [2:0] ST_T2   = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_T3   = 3'd4;
  localparam logic [2:0] ST_T4   = 3'd5;

  // Counter value on the final wait cycle; unused when WAIT_STATES is zero.
  localparam logic [3:0] WaitLast = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam bit         HasWait  = (WAIT_STATES != 0);

  logic [2:0]   state_q, state_d;
  logic [3:0]   wait_cnt_q, wait_cnt_d;
  logic         rw_q, rw_d;
  regfile_r8_t  dest_q, dest_d;
  logic [15:0]  addr_q, addr_d;
  logic [7:0]   wdata_q, wdata_d;
  logic         rd_q, rd_d;
  logic         wr_q, wr_d;
  regfile_r8_t  db_req_q, db_req_d;
  logic [7:0]   db_data_q, db_data_d;
  logic         db_wren_q, db_wren_d;
  logic         bad_dest_q, bad_dest_d;

  logic         accept;
  logic [15:0]  req_addr;
  logic         dest_legal;
  logic         read_return;

  assign req_ready = ~reset & ((state_q == ST_IDLE) | (state_q == ST_T4));
  assign accept    = req_valid & req_ready;

  // Address source: full register pair, or the LDH high page with the pair's low byte.
  assign req_addr = req_high_page
                  ? {8'hFF, getRegisterLow(registers, req_addr_sel)}
                  : {getRegisterHigh(registers, req_addr_sel),
                     getRegisterLow(registers, req_addr_sel)};

  assign dest_legal  = (dest_q == REG_IR) | (dest_q == REG_TMP_L) | (dest_q == REG_TMP_H);
  // Read data is captured on the edge that leaves T3 and presented during T4.
  assign read_return = (state_q == ST_T3) & ~rw_q;

  // Bus cycle sequencing and wait-state counting.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_T1;
      ST_T1:   state_d = ST_T2;
      ST_T2: begin
        wait_cnt_d = 4'd0;
        state_d    = HasWait ? ST_WAIT : ST_T3;
      end
      ST_WAIT: begin
        if (wait_cnt_q == WaitLast) begin
          wait_cnt_d = 4'd0;
          state_d    = ST_T3;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      ST_T3:   state_d = ST_T4;
      ST_T4:   state_d = accept ? ST_T1 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture on accept; values are frozen for the whole access.
  always_comb begin
    rw_d    = rw_q;
    dest_d  = dest_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept) begin
      rw_d    = req_write;
      dest_d  = req_dest;
      addr_d  = req_addr;
      wdata_d = registers[req_wdata_sel];
    end
  end

  // Strobes are decoded from the next state so they appear registered in the matching phase.
  always_comb begin
    rd_d = ~rw_d & ((state_d == ST_T1) | (state_d == ST_T2) |
                    (state_d == ST_WAIT) | (state_d == ST_T3));
    wr_d =  rw_d & ((state_d == ST_T2) | (state_d == ST_WAIT) | (state_d == ST_T3));
  end

  // Read-return port toward the register file; illegal targets raise bad_dest instead.
  always_comb begin
    db_req_d   = db_req_q;
    db_data_d  = db_data_q;
    db_wren_d  = 1'b0;
    bad_dest_d = 1'b0;
    if (read_return) begin
      db_req_d   = dest_q;
      db_data_d  = mem_rdata;
      db_wren_d  = dest_legal;
      bad_dest_d = ~dest_legal;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      rw_q       <= 1'b0;
      dest_q     <= REG_IR;
      addr_q     <= 16'h0000;
      wdata_q    <= 8'h00;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      db_req_q   <= REG_IR;
      db_data_q  <= 8'h00;
      db_wren_q  <= 1'b0;
      bad_dest_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rw_q       <= rw_d;
      dest_q     <= dest_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      db_req_q   <= db_req_d;
      db_data_q  <= db_data_d;
      db_wren_q  <= db_wren_d;
      bad_dest_q <= bad_dest_d;
    end
  end

  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_rd        = rd_q;
  assign mem_wr        = wr_q;
  assign data_bus_req  = db_req_q;
  assign data_bus_data = db_data_q;
  assign data_bus_wren = db_wren_q;
  assign bad_dest      = bad_dest_q;

endmodule

// File: tb/tb_gb_cpu_bus_ctrl.sv
// Bench for gb_cpu_bus_ctrl: directed scenarios followed by random traffic, every cycle
// compared against a transaction-offset model of the bus access.
module tb_gb_cpu_bus_ctrl;
  import gb_cpu_bus_pkg::*;

  localparam int unsigned WS = 2;
  localparam int Last  = 3 + WS;  // offset of T4 from T1
  localparam int T3Off = 2 + WS;  // offset of T3 from T1

  logic         clk;
  logic         reset;
  regfile_t     registers;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  regfile_r16_t req_addr_sel;
  logic         req_high_page;
  regfile_r8_t  req_wdata_sel;
  regfile_r8_t  req_dest;
  logic [15:0]  mem_addr;
  logic [7:0]   mem_wdata;
  logic         mem_rd;
  logic         mem_wr;
  logic [7:0]   mem_rdata;
  regfile_r8_t  data_bus_req;
  logic [7:0]   data_bus_data;
  logic         data_bus_wren;
  logic         bad_dest;

  gb_cpu_bus_ctrl #(.WAIT_STATES(WS)) dut (
    .clk           (clk),
    .reset         (reset),
    .registers     (registers),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr_sel  (req_addr_sel),
    .req_high_page (req_high_page),
    .req_wdata_sel (req_wdata_sel),
    .req_dest      (req_dest),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .mem_rdata     (mem_rdata),
    .data_bus_req  (data_bus_req),
    .data_bus_data (data_bus_data),
    .data_bus_wren (data_bus_wren),
    .bad_dest      (bad_dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  // Model: an access is tracked by its cycle offset k from T1.
  bit          m_active = 1'b0;
  int          m_k      = 0;
  bit          m_rw     = 1'b0;
  regfile_r8_t m_dest   = REG_IR;
  logic [15:0] m_addr   = 16'h0000;
  logic [7:0]  m_wdata  = 8'h00;
  regfile_r8_t m_dbreq  = REG_IR;
  logic [7:0]  m_dbdata = 8'h00;
  bit          m_wren   = 1'b0;
  bit          m_bad    = 1'b0;

  function automatic logic [15:0] model_addr(regfile_t r, regfile_r16_t sel, bit hp);
    logic [7:0] hi, lo;
    case (sel)
      REG_AF:  begin hi = r[REG_A];    lo = r[REG_F];    end
      REG_BC:  begin hi = r[REG_B];    lo = r[REG_C];    end
      REG_DE:  begin hi = r[REG_D];    lo = r[REG_E];    end
      REG_HL:  begin hi = r[REG_H];    lo = r[REG_L];    end
      REG_SP:  begin hi = r[REG_SP_H]; lo = r[REG_SP_L]; end
      REG_PC:  begin hi = r[REG_PC_H]; lo = r[REG_PC_L]; end
      default: begin hi = r[REG_TMP_H]; lo = r[REG_TMP_L]; end
    endcase
    return hp ? {8'hFF, lo} : {hi, lo};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic tick();
    bit ready_pre, accept_pre, leave_t3, legal, exp_rd, exp_wr, exp_ready;
    ready_pre  = !reset && (!m_active || m_k == Last);
    accept_pre = req_valid && ready_pre;
    leave_t3   = m_active && m_k == T3Off && !m_rw;
    @(posedge clk);
    #1;
    cycle++;
    if (reset) begin
      m_active = 1'b0;
      m_addr   = 16'h0000;
      m_wdata  = 8'h00;
      m_dbreq  = REG_IR;
      m_dbdata = 8'h00;
      m_wren   = 1'b0;
      m_bad    = 1'b0;
    end else begin
      m_wren = 1'b0;
      m_bad  = 1'b0;
      if (leave_t3) begin
        legal    = (m_dest == REG_IR) || (m_dest == REG_TMP_L) || (m_dest == REG_TMP_H);
        m_dbreq  = m_dest;
        m_dbdata = mem_rdata;
        m_wren   = legal;
        m_bad    = !legal;
      end
      if (accept_pre) begin
        m_active = 1'b1;
        m_k      = 0;
        m_rw     = req_write;
        m_dest   = req_dest;
        m_addr   = model_addr(registers, req_addr_sel, req_high_page);
        m_wdata  = registers[req_wdata_sel];
      end else if (m_active) begin
        if (m_k == Last) m_active = 1'b0;
        else m_k++;
      end
    end
    exp_rd    = m_active && !m_rw && m_k <= T3Off;
    exp_wr    = m_active && m_rw && m_k >= 1 && m_k <= T3Off;
    exp_ready = !reset && (!m_active || m_k == Last);
    chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    chk("mem_rd", 32'(mem_rd), 32'(exp_rd));
    chk("mem_wr", 32'(mem_wr), 32'(exp_wr));
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("db_req", 32'(data_bus_req), 32'(m_dbreq));
    chk("db_data", 32'(data_bus_data), 32'(m_dbdata));
    chk("db_wren", 32'(data_bus_wren), 32'(m_wren));
    chk("bad_dest", 32'(bad_dest), 32'(m_bad));
    chk("strobe_excl", 32'(mem_rd & mem_wr), 32'd0);
  endtask

  task automatic wait_wren(input string tag, output int at);
    int n = 0;
    while (!data_bus_wren && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_wren_seen"}, 32'(data_bus_wren), 32'd1);
    at = cycle;
  endtask

  initial begin
    int c_acc, c_a, c_b, rd_cnt, wr_cnt, wren_cnt, bad_cnt;
    logic [7:0] rb;

    reset         = 1'b1;
    registers     = '0;
    req_valid     = 1'b0;
    req_write     = 1'b0;
    req_addr_sel  = REG_PC;
    req_high_page = 1'b0;
    req_wdata_sel = REG_A;
    req_dest      = REG_IR;
    mem_rdata     = 8'h00;

    // Reset state
    tick();
    tick();
    chk("ready_in_reset", 32'(req_ready), 32'd0);
    chk("reset_addr", 32'(mem_addr), 32'h0000);
    reset = 1'b0;
    tick();
    chk("ready_after_reset", 32'(req_ready), 32'd1);

    // Opcode fetch from PC into IR, PC changed mid-access
    registers[REG_PC_H] = 8'h01;
    registers[REG_PC_L] = 8'h50;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr_sel = REG_PC;
    req_dest = REG_IR;
    mem_rdata = 8'h3E;
    tick();
    c_acc = cycle - 1;
    req_valid = 1'b0;
    registers[REG_PC_H] = 8'hDE;
    chk("fetch_addr_t1", 32'(mem_addr), 32'h0150);
    chk("fetch_rd_t1", 32'(mem_rd), 32'd1);
    wait_wren("fetch", c_a);
    chk("fetch_latency", 32'(c_a - c_acc), 32'(4 + WS));
    chk("fetch_data", 32'(data_bus_data), 32'h3E);
    chk("fetch_dest", 32'(data_bus_req), 32'(REG_IR));
    chk("fetch_addr_t4", 32'(mem_addr), 32'h0150);
    tick();
    chk("fetch_wren_once", 32'(data_bus_wren), 32'd0);

    // Write A to (HL)
    registers[REG_H] = 8'hC0;
    registers[REG_L] = 8'h00;
    registers[REG_A] = 8'h5A;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr_sel = REG_HL;
    req_wdata_sel = REG_A;
    tick();
    req_valid = 1'b0;
    registers[REG_A] = 8'hFF;
    rd_cnt = int'(mem_rd);
    wr_cnt = int'(mem_wr);
    wren_cnt = int'(data_bus_wren);
    for (int i = 1; i <= Last; i++) begin
      tick();
      rd_cnt += int'(mem_rd);
      wr_cnt += int'(mem_wr);
      wren_cnt += int'(data_bus_wren);
    end
    chk("write_addr", 32'(mem_addr), 32'hC000);
    chk("write_data", 32'(mem_wdata), 32'h5A);
    chk("write_wr_cycles", 32'(wr_cnt), 32'(2 + WS));
    chk("write_rd_cycles", 32'(rd_cnt), 32'd0);
    chk("write_no_wren", 32'(wren_cnt), 32'd0);
    tick();

    // LDH read from FF00+C into TMP_L
    registers[REG_B] = 8'h12;
    registers[REG_C] = 8'h44;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr_sel = REG_BC;
    req_high_page = 1'b1;
    req_dest = REG_TMP_L;
    rb = 8'($urandom);
    mem_rdata = rb;
    tick();
    req_valid = 1'b0;
    req_high_page = 1'b0;
    chk("ldh_addr", 32'(mem_addr), 32'hFF44);
    wait_wren("ldh", c_a);
    chk("ldh_dest", 32'(data_bus_req), 32'(REG_TMP_L));
    chk("ldh_data", 32'(data_bus_data), 32'(rb));
    tick();

    // Back-to-back reads with valid held
    registers[REG_PC_H] = 8'h01;
    registers[REG_PC_L] = 8'h00;
    req_valid = 1'b1;
    req_addr_sel = REG_PC;
    req_dest = REG_IR;
    tick();
    registers[REG_PC_L] = 8'h01;
    wait_wren("b2b1", c_a);
    chk("b2b_ready_t4", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("b2b_addr2", 32'(mem_addr), 32'h0101);
    chk("b2b_rd2", 32'(mem_rd), 32'd1);
    wait_wren("b2b2", c_b);
    chk("b2b_gap", 32'(c_b - c_a), 32'(4 + WS));
    tick();

    // Read with illegal destination, also counts read strobe length
    req_valid = 1'b1;
    req_write = 1'b0;
    req_dest = REG_B;
    tick();
    req_valid = 1'b0;
    rd_cnt = int'(mem_rd);
    wren_cnt = 0;
    bad_cnt = 0;
    for (int i = 1; i <= Last + 1; i++) begin
      tick();
      rd_cnt += int'(mem_rd);
      wren_cnt += int'(data_bus_wren);
      bad_cnt += int'(bad_dest);
    end
    chk("bad_rd_cycles", 32'(rd_cnt), 32'(3 + WS));
    chk("bad_no_wren", 32'(wren_cnt), 32'd0);
    chk("bad_pulse", 32'(bad_cnt), 32'd1);

    // Reset during T2 of a write, request held valid through reset
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr_sel = REG_HL;
    tick();
    tick();
    chk("rst_wr_t2", 32'(mem_wr), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_ready_low", 32'(req_ready), 32'd0);
    tick();
    chk("rst_wr_dropped", 32'(mem_wr), 32'd0);
    tick();
    chk("rst_no_accept", 32'(mem_rd | mem_wr), 32'd0);
    req_valid = 1'b0;
    reset = 1'b0;
    tick();
    chk("rst_ready_release", 32'(req_ready), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      req_valid = ($urandom_range(0, 2) != 0);
      req_write = 1'($urandom_range(0, 1));
      req_addr_sel = regfile_r16_t'(3'($urandom_range(0, 6)));
      req_high_page = ($urandom_range(0, 3) == 0);
      req_wdata_sel = regfile_r8_t'(4'($urandom_range(0, 15)));
      case ($urandom_range(0, 3))
        0:       req_dest = regfile_r8_t'(4'($urandom_range(0, 15)));
        1:       req_dest = REG_TMP_H;
        2:       req_dest = REG_TMP_L;
        default: req_dest = REG_IR;
      endcase
      mem_rdata = 8'($urandom);
      if ($urandom_range(0, 2) == 0) registers = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    reset = 1'b0;
    req_valid = 1'b0;
    for (int i = 0; i < Last + 2; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gb_cpu_bus_ctrl.md
GB_CPU_BUS_CTRL -- requirements
Module: gb_cpu_bus_ctrl

Interface
REQ-001 Parameter WAIT_STATES, default 0, number of extra cycles inserted between T2 and T3 (range 0-15).
REQ-002 clk  input  1  machine clock; all state updates on posedge.
REQ-003 reset  input  1  reset, synchronous, active-high; clock clk.
REQ-004 registers  input  regfile_t  current register file contents, used as the address and write-data source.
REQ-005 req_valid  input  1  bus access request from the control unit.
REQ-006 req_ready  output  1  controller accepts a request this cycle.
REQ-007 req_write  input  1  1 = memory write, 0 = memory read.
REQ-008 req_addr_sel  input  regfile_r16_t  register pair supplying the address.
REQ-009 req_high_page  input  1  address = {8'hFF, low byte of req_addr_sel} (LDH).
REQ-010 req_wdata_sel  input  regfile_r8_t  register supplying write data.
REQ-011 req_dest  input  regfile_r8_t  read destination (REG_IR, REG_TMP_L or REG_TMP_H).
REQ-012 mem_addr  output  16  memory address bus.
REQ-013 mem_wdata  output  8  memory write data.
REQ-014 mem_rd  output  1  read strobe.
REQ-015 mem_wr  output  1  write strobe.
REQ-016 mem_rdata  input  8  memory read data.
REQ-017 data_bus_req / data_bus_data / data_bus_wren  output  regfile_r8_t / 8 / 1  read-return write port toward the register file.
REQ-018 bad_dest  output  1  one-cycle pulse: read completed with an illegal req_dest.

Function
REQ-019 States: IDLE, T1, T2, WAIT, T3, T4; all outputs except req_ready registered.
REQ-020 req_ready = 1 in IDLE and T4, 0 elsewhere and 0 while reset is high.
REQ-021 Accept = req_valid & req_ready; on accept, latch address, write data (registers value of req_wdata_sel at that edge), rw and dest; next state T1.
REQ-022 Address = {high reg, low reg} of req_addr_sel via getRegisterHigh/getRegisterLow; if req_high_page, {8'hFF, low reg}.
REQ-023 mem_addr holds the latched address from T1 through T4 and retains it in IDLE until the next accept.
REQ-024 Transitions: T1->T2; T2->WAIT if WAIT_STATES>0 else T3; WAIT held for exactly WAIT_STATES cycles via 4-bit counter, then T3; T3->T4; T4->T1 on accept, else IDLE.
REQ-025 Read: mem_rd = 1 in T1, T2, WAIT, T3; mem_wr = 0 throughout.
REQ-026 Read: mem_rdata sampled on the edge leaving T3; in T4 data_bus_wren = 1, data_bus_req = dest, data_bus_data = sampled byte, for exactly one cycle.
REQ-027 Read with dest not in {REG_IR, REG_TMP_L, REG_TMP_H}: data_bus_wren stays 0 and bad_dest pulses 1 in T4.
REQ-028 Write: mem_wdata valid T1..T4; mem_wr = 1 in T2, WAIT, T3; mem_rd = 0 throughout; data_bus_wren = 0.
REQ-029 Writes never drive data_bus_wren; reads never drive mem_wr; both strobes never high in the same cycle.
REQ-030 Back-to-back accept in T4: T4 outputs of the old access complete, new address appears in T1 of the next cycle; no IDLE bubble.
REQ-031 Register changes after accept do not affect the latched address/data of the access in flight.
REQ-032 Access latency: accept edge to data_bus_wren = 4 + WAIT_STATES cycles.

Reset
REQ-033 Reset is synchronous: at a posedge with reset high, state = IDLE, WAIT counter = 0, mem_addr = 16'h0000, mem_wdata = 8'h00, mem_rd = 0, mem_wr = 0, data_bus_req = REG_IR, data_bus_data = 8'h00, data_bus_wren = 0, bad_dest = 0.
REQ-034 Reset mid-access aborts it: strobes drop at that edge, no data_bus_wren is issued, a request held valid during reset is not accepted.

Verification
REQ-035 PC=16'h0150, read req_addr_sel=REG_PC, dest=REG_IR, mem_rdata=8'h3E in T3 -> mem_addr=16'h0150 T1..T4, mem_rd T1..T3, T4 data_bus_req=REG_IR, data_bus_data=8'h3E, data_bus_wren=1 for one cycle.
REQ-036 HL=16'hC000, A=8'h5A, write wdata_sel=REG_A -> mem_addr=16'hC000, mem_wdata=8'h5A T1..T4, mem_wr T2..T3, mem_rd=0, data_bus_wren=0.
REQ-037 C=8'h44, req_high_page=1, addr_sel=REG_BC, read to REG_TMP_L -> mem_addr=16'hFF44; TMP_L write in T4.
REQ-038 Two reads held valid back-to-back (PC 16'h0100 then 16'h0101) -> second T1 immediately follows first T4; two data_bus_wren pulses 4 cycles apart.
REQ-039 WAIT_STATES=2, read -> mem_rd high 5 cycles, data_bus_wren 6 cycles after accept; read with dest=REG_B -> bad_dest pulse, no data_bus_wren.
REQ-040 Reset asserted in T2 of a write -> mem_wr=0 and state IDLE after that edge; req_ready=0 while reset high, =1 the cycle after release.
